// File: rtl/fifo36_frame_arbiter_pkg.sv
// Shared constants for the fifo36 frame arbiter: word bit positions, state encoding, port count.
package fifo36_frame_arbiter_pkg;

  localparam int FIFO36_SOF    = 32;
  localparam int FIFO36_EOF    = 33;
  localparam int FIFO36_OCC_LO = 34;
  localparam int FIFO36_OCC_HI = 35;

  localparam int ARB_PORTS = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } arb_state_e;

  function automatic logic is_eof(input logic [35:0] word);
    return word[FIFO36_EOF];
  endfunction

endpackage

// File: rtl/fifo36_rr_pick.sv
// Combinational 4-way picker: round-robin from last+1, or fixed priority with port 0 highest.
module fifo36_rr_pick
  import fifo36_frame_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  input  logic       mode,
  output logic [1:0] win,
  output logic       valid
);

  logic [1:0] idx;

  always_comb begin
    win   = last;
    valid = |req;
    idx   = '0;
    if (mode) begin
      for (int i = ARB_PORTS - 1; i >= 0; i--) begin
        if (req[i]) win = 2'(i);
      end
    end else begin
      // Scan downward so the smallest offset from last+1 is the one that sticks.
      for (int k = ARB_PORTS; k >= 1; k--) begin
        idx = last + 2'(k);
        if (req[idx]) win = idx;
      end
    end
  end

endmodule

// File: rtl/fifo36_frame_arbiter.sv
// Frame-atomic 4:1 arbiter for a fifo36 src_rdy/dst_rdy link, zero-latency once granted.
// Optional per-port EOF frame counters are built when FIFO36_ARB_FRAME_CNT_EN is defined.
//
//   state     | meaning
//   ST_IDLE   | no grant held; picks a winner from src_rdy_i when any is set
//   ST_ACTIVE | grant held on grant_o until an EOF word transfers
module fifo36_frame_arbiter
  import fifo36_frame_arbiter_pkg::*;
#(
  parameter int PRIORITY = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [143:0] data_i,
  input  logic [3:0]   src_rdy_i,
  output logic [3:0]   dst_rdy_o,
  output logic [35:0]  data_o,
  output logic         src_rdy_o,
  input  logic         dst_rdy_i,
  output logic         busy_o,
  output logic [1:0]   grant_o
`ifdef FIFO36_ARB_FRAME_CNT_EN
  ,
  input  logic [1:0]   cnt_sel_i,
  output logic [15:0]  frame_cnt_o
`endif
);

  localparam logic PRI_MODE = (PRIORITY != 0);

  arb_state_e  state, state_nxt;
  logic [1:0]  grant, grant_nxt;
  logic [35:0] words [ARB_PORTS];
  logic [35:0] sel_word;
  logic        sel_src;
  logic        xfer_out;
  logic        eof_xfer;
  logic [1:0]  pick_win;
  logic        pick_valid;

  always_comb begin
    for (int i = 0; i < ARB_PORTS; i++) begin
      words[i] = data_i[36*i +: 36];
    end
  end

  assign sel_word = words[grant];
  assign sel_src  = src_rdy_i[grant];
  assign xfer_out = (state == ST_ACTIVE) & sel_src & dst_rdy_i;
  assign eof_xfer = xfer_out & is_eof(sel_word);

  fifo36_rr_pick u_pick (
    .req   (src_rdy_i),
    .last  (grant),
    .mode  (PRI_MODE),
    .win   (pick_win),
    .valid (pick_valid)
  );

  // Grant resets to 3 so round-robin starts its scan at port 0.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state <= ST_IDLE;
      grant <= 2'd3;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nxt = ST_ACTIVE;
          grant_nxt = pick_win;
        end
      end
      ST_ACTIVE: begin
        if (eof_xfer) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    data_o    = sel_word;
    src_rdy_o = 1'b0;
    dst_rdy_o = '0;
    if (state == ST_ACTIVE) begin
      src_rdy_o        = sel_src;
      dst_rdy_o[grant] = dst_rdy_i;
    end
  end

  assign busy_o  = (state == ST_ACTIVE);
  assign grant_o = grant;

`ifdef FIFO36_ARB_FRAME_CNT_EN
  logic [15:0] frame_cnt [ARB_PORTS];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < ARB_PORTS; i++) frame_cnt[i] <= '0;
    end else if (eof_xfer) begin
      frame_cnt[grant] <= frame_cnt[grant] + 16'd1;
    end
  end

  assign frame_cnt_o = frame_cnt[cnt_sel_i];
`endif

endmodule

// File: tb/tb_fifo36_frame_arbiter.sv
// Scoreboard bench: round-robin and fixed-priority instances, each fed by its own frame sources.
module tb_fifo36_frame_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, clear;
  logic [143:0] data_i    [2];
  logic [3:0]   src_rdy_i [2];
  logic [3:0]   dst_rdy_o [2];
  logic [35:0]  data_o    [2];
  logic         src_rdy_o [2];
  logic         dst_rdy_i [2];
  logic         busy_o    [2];
  logic [1:0]   grant_o   [2];
  logic [1:0]   cnt_sel   [2];
  logic [15:0]  frame_cnt [2];

  fifo36_frame_arbiter #(.PRIORITY(0)) dut_rr (
    .clk(clk), .reset(reset), .clear(clear),
    .data_i(data_i[0]), .src_rdy_i(src_rdy_i[0]), .dst_rdy_o(dst_rdy_o[0]),
    .data_o(data_o[0]), .src_rdy_o(src_rdy_o[0]), .dst_rdy_i(dst_rdy_i[0]),
    .busy_o(busy_o[0]),
`ifdef FIFO36_ARB_FRAME_CNT_EN
    .cnt_sel_i(cnt_sel[0]), .frame_cnt_o(frame_cnt[0]),
`endif
    .grant_o(grant_o[0])
  );

  fifo36_frame_arbiter #(.PRIORITY(1)) dut_fp (
    .clk(clk), .reset(reset), .clear(clear),
    .data_i(data_i[1]), .src_rdy_i(src_rdy_i[1]), .dst_rdy_o(dst_rdy_o[1]),
    .data_o(data_o[1]), .src_rdy_o(src_rdy_o[1]), .dst_rdy_i(dst_rdy_i[1]),
    .busy_o(busy_o[1]),
`ifdef FIFO36_ARB_FRAME_CNT_EN
    .cnt_sel_i(cnt_sel[1]), .frame_cnt_o(frame_cnt[1]),
`endif
    .grant_o(grant_o[1])
  );

  int total = 0;
  int bad   = 0;

  logic [35:0] srcq [2][4][$];
  logic [37:0] expq [2][$];
  int          order_q[$];

  int  vpct = 100;
  int  dpct = 100;
  bit  mon_en = 1'b0;
  bit  rec_order = 1'b0;

  bit          m_busy  [2];
  int          m_grant [2];
  int          m_cnt   [2][4];
  logic        exp_busy [2];
  logic [1:0]  exp_grant[2];
  logic [35:0] exp_data [2];
  logic        exp_src  [2];
  logic [3:0]  exp_dst  [2];
  logic [15:0] exp_cnt  [2];

  task automatic chk(input int d, input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL dut%0d %s actual=%h required=%h t=%0t", d, name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] mkword(input int idx, input int len);
    logic [31:0] pay;
    logic [1:0]  occ;
    pay = $urandom;
    occ = 2'($urandom);
    return {occ, (idx == len - 1) ? 1'b1 : 1'b0, (idx == 0) ? 1'b1 : 1'b0, pay};
  endfunction

  task automatic push_frame(input int d, input int p, input int len);
    for (int i = 0; i < len; i++) srcq[d][p].push_back(mkword(i, len));
  endtask

  // Reference winner: round-robin starts at last+1, fixed priority takes the lowest port.
  function automatic int pick(input bit fixed, input logic [3:0] req, input int last);
    if (fixed) begin
      for (int i = 0; i < 4; i++) if (req[i]) return i;
    end else begin
      for (int off = 1; off <= 4; off++) if (req[(last + off) % 4]) return (last + off) % 4;
    end
    return last;
  endfunction

  task automatic drive();
    logic [143:0] dv;
    logic [3:0]   sv;
    for (int d = 0; d < 2; d++) begin
      dv = '0;
      sv = '0;
      for (int p = 0; p < 4; p++) begin
        if (srcq[d][p].size() > 0) begin
          dv[36*p +: 36] = srcq[d][p][0];
          sv[p] = ($urandom_range(99) < vpct);
        end else begin
          dv[36*p +: 36] = {4'($urandom), 32'($urandom)};
        end
      end
      data_i[d]    = dv;
      src_rdy_i[d] = sv;
      dst_rdy_i[d] = ($urandom_range(99) < dpct);
      cnt_sel[d]   = 2'($urandom);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive();
  endtask

  // Reference model: evaluates each cycle once inputs are stable, then advances its state.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int          g;
      logic [35:0] w;
      bit          xfer;
      g = m_grant[d];
      w = data_i[d][36*g +: 36];
      exp_busy[d]  = m_busy[d];
      exp_grant[d] = 2'(g);
      exp_data[d]  = w;
      exp_src[d]   = 1'b0;
      exp_dst[d]   = '0;
      exp_cnt[d]   = 16'(m_cnt[d][cnt_sel[d]]);
      xfer = 1'b0;
      if (m_busy[d]) begin
        exp_src[d] = src_rdy_i[d][g];
        if (dst_rdy_i[d]) exp_dst[d] = 4'(1 << g);
        xfer = src_rdy_i[d][g] & dst_rdy_i[d];
      end
      if (xfer) begin
        expq[d].push_back({2'(g), w});
        void'(srcq[d][g].pop_front());
      end
      if (reset || clear) begin
        m_busy[d]  = 1'b0;
        m_grant[d] = 3;
        for (int p = 0; p < 4; p++) m_cnt[d][p] = 0;
      end else if (m_busy[d]) begin
        if (xfer && w[33]) begin
          m_busy[d] = 1'b0;
          m_cnt[d][g] = (m_cnt[d][g] + 1) % 65536;
        end
      end else if (src_rdy_i[d] != 4'b0) begin
        m_grant[d] = pick(d == 1, src_rdy_i[d], g);
        m_busy[d]  = 1'b1;
      end
    end
  end

  // Monitor: compares every visible output and pops the scoreboard on each output transfer.
  always @(negedge clk) begin
    logic [37:0] e;
    #2;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        chk(d, "busy_o", 64'(busy_o[d]), 64'(exp_busy[d]));
        chk(d, "grant_o", 64'(grant_o[d]), 64'(exp_grant[d]));
        chk(d, "src_rdy_o", 64'(src_rdy_o[d]), 64'(exp_src[d]));
        chk(d, "dst_rdy_o", 64'(dst_rdy_o[d]), 64'(exp_dst[d]));
        chk(d, "data_o", 64'(data_o[d]), 64'(exp_data[d]));
`ifdef FIFO36_ARB_FRAME_CNT_EN
        chk(d, "frame_cnt_o", 64'(frame_cnt[d]), 64'(exp_cnt[d]));
`endif
        if (src_rdy_o[d] && dst_rdy_i[d]) begin
          if (expq[d].size() == 0) begin
            chk(d, "unexpected_xfer", 64'(1), 64'(0));
          end else begin
            e = expq[d].pop_front();
            chk(d, "xfer_word", 64'({grant_o[d], data_o[d]}), 64'(e));
            if (d == 0 && rec_order && data_o[d][32]) order_q.push_back(int'(grant_o[d]));
          end
        end
      end
    end
  end

  function automatic bit all_drained();
    for (int d = 0; d < 2; d++) begin
      if (m_busy[d]) return 1'b0;
      for (int p = 0; p < 4; p++) if (srcq[d][p].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin
    int exp_order[5];
    int steps;
    exp_order = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    clear = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0;
      m_grant[d] = 3;
      for (int p = 0; p < 4; p++) m_cnt[d][p] = 0;
    end
    drive();
    repeat (3) cycle();
    mon_en = 1'b1;
    reset = 1'b0;

    // Single 3-word frame on port 2.
    for (int d = 0; d < 2; d++) begin
      srcq[d][2].push_back({4'h0, 32'h0000_000A} | (36'h1 << 32));
      srcq[d][2].push_back({4'h0, 32'h0000_000B});
      srcq[d][2].push_back({4'h0, 32'h0000_000C} | (36'h1 << 33));
    end
    vpct = 100; dpct = 100;
    repeat (8) cycle();

    // All ports request back-to-back 2-word frames.
    reset = 1'b1; cycle(); reset = 1'b0;
    rec_order = 1'b1;
    for (int n = 0; n < 40; n++) begin
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 4; p++)
          if (srcq[d][p].size() < 3) push_frame(d, p, 2);
      cycle();
    end
    rec_order = 1'b0;
    chk(0, "rr_order_len", 64'(order_q.size() >= 5), 64'(1));
    if (order_q.size() >= 5)
      for (int i = 0; i < 5; i++) chk(0, "rr_order", 64'(order_q[i]), 64'(exp_order[i]));

    // Drain, then only ports 1 and 3 request continuously.
    vpct = 100; dpct = 100;
    steps = 0;
    while (!all_drained() && steps < 400) begin cycle(); steps++; end
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      for (int d = 0; d < 2; d++) begin
        if (srcq[d][1].size() < 3) push_frame(d, 1, 2);
        if (srcq[d][3].size() < 3) push_frame(d, 3, 2);
      end
      cycle();
    end

    // Random traffic with stalls on both sides, plus occasional reset and clear mid-frame.
    vpct = 70; dpct = 70;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(249) == 0);
      clear = ($urandom_range(249) == 0);
      for (int d = 0; d < 2; d++)
        if ($urandom_range(99) < 12) begin
          int p;
          p = $urandom_range(3);
          if (srcq[d][p].size() < 10) push_frame(d, p, $urandom_range(1, 5));
        end
      cycle();
    end

    reset = 1'b0; clear = 1'b0;
    vpct = 100; dpct = 100;
    steps = 0;
    while (!all_drained() && steps < 2000) begin cycle(); steps++; end
    chk(0, "drain_done", 64'(all_drained()), 64'(1));
    repeat (3) cycle();
    for (int d = 0; d < 2; d++) chk(d, "scoreboard_empty", 64'(expq[d].size()), 64'(0));

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
